addend_collector: RTL and testbench

- Producer side of the adder_tree addends interface.
- Accepts fixed-point values one per cycle over a valid/ready stream and packs them into lanes 0..NUM_NODES-1 of a flat vector.
- Presents the completed vector, with a valid/ready handshake, to the adder_tree `addends` input.
- Short vectors (terminated early by `in_last`) are zero-padded, so the tree sum is unaffected.

---
 rtl/addend_collector_pkg.sv | 18 +
 rtl/addend_collector.sv | 141 ++++++++++++++
 tb/tb_addend_collector.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/addend_collector_pkg.sv
// addend_collector_pkg
//   Shared definitions for the adder_tree addend collector: collector state
//   encoding and the lane-slice helper that the adder_tree also uses to
//   locate lane i inside the flat addends vector.
package addend_collector_pkg;

    typedef enum logic {
        COLLECTOR_FILL = 1'b0,
        COLLECTOR_HOLD = 1'b1
    } collector_state_e;

    // LSB position of lane `lane` in a flat vector of `width`-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/addend_collector.sv
// addend_collector
//   Producer side of the adder_tree addends interface. Values arrive one per
//   cycle over a valid/ready stream and are packed into lanes 0..NUM_NODES-1.
//   A vector closes when the last lane is written or in_last is seen; unused
//   lanes stay zero so the tree sum is unaffected. The finished vector is
//   held with out_valid until the consumer takes it with out_ready.
//
//   Optional feature: define ADDEND_COLLECTOR_SUM_EN to add the partial_sum
//   output, a running modulo-2^PRECISION_BITS sum of the accepted values.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    in_data valid this cycle
//   in_ready    collector accepts a value this cycle (registered, FILL)
//   in_data     value for the next free lane
//   in_last     closes the current vector (qualified by in_valid)
//   out_valid   addends holds a complete vector (registered, HOLD)
//   out_ready   consumer takes the vector this cycle
//   addends     packed vector, lane i at [i*PRECISION_BITS +: PRECISION_BITS]
//   partial_sum running sum of accepted values (ADDEND_COLLECTOR_SUM_EN only)
//   out_count   number of lanes written in the held vector (0 while filling)
module addend_collector
    import addend_collector_pkg::*;
#(
    parameter int unsigned PRECISION_BITS = 8,
    parameter int unsigned NUM_NODES      = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [PRECISION_BITS-1:0]           in_data,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [PRECISION_BITS*NUM_NODES-1:0] addends,
`ifdef ADDEND_COLLECTOR_SUM_EN
    output logic [PRECISION_BITS-1:0]           partial_sum,
`endif
    output logic [$clog2(NUM_NODES+1)-1:0]      out_count
);

    localparam int unsigned IDX_W = $clog2(NUM_NODES);
    localparam int unsigned CNT_W = $clog2(NUM_NODES+1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    collector_state_e          r_state;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [CNT_W-1:0]          r_out_count;
    logic [PRECISION_BITS-1:0] r_lane [NUM_NODES];

    logic w_accept;
    logic w_release;
    logic w_close;

    assign w_accept  = in_valid & r_in_ready;
    assign w_release = r_out_valid & out_ready;
    assign w_close   = (r_idx == LAST_IDX) | in_last;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_count = r_out_count;

    // Control FSM; in_ready/out_valid are registered alongside the state so
    // neither output depends combinationally on any input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= COLLECTOR_FILL;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                COLLECTOR_FILL: begin
                    if (in_valid) begin
                        r_idx <= r_idx + IDX_W'(1);
                        if (w_close) begin
                            r_state     <= COLLECTOR_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_count <= CNT_W'(r_idx) + CNT_W'(1);
                        end
                    end
                end
                COLLECTOR_HOLD: begin
                    if (out_ready) begin
                        r_state     <= COLLECTOR_FILL;
                        r_idx       <= '0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_out_count <= '0;
                    end
                end
                default: begin
                    r_state     <= COLLECTOR_FILL;
                    r_idx       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_count <= '0;
                end
            endcase
        end
    end

    // Lane registers: per-lane write enable on the current index, common
    // clear on the output handshake so a short vector never sees stale lanes.
    for (genvar i = 0; i < NUM_NODES; i++) begin : g_lane
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lane[i] <= '0;
            end else if (w_release) begin
                r_lane[i] <= '0;
            end else if (w_accept && (r_idx == IDX_W'(i))) begin
                r_lane[i] <= in_data;
            end
        end
        assign addends[lane_lsb(i, PRECISION_BITS) +: PRECISION_BITS] = r_lane[i];
    end

`ifdef ADDEND_COLLECTOR_SUM_EN
    logic [PRECISION_BITS-1:0] r_partial_sum;

    // Wraps modulo 2^PRECISION_BITS, matching adder_tree truncation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_partial_sum <= '0;
        end else if (w_release) begin
            r_partial_sum <= '0;
        end else if (w_accept) begin
            r_partial_sum <= r_partial_sum + in_data;
        end
    end

    assign partial_sum = r_partial_sum;
`endif

endmodule

// File: tb/tb_addend_collector.sv
module tb_addend_collector;

    localparam int unsigned P = 8;
    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [P-1:0]   in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [P*N-1:0] addends;
    logic [2:0]     out_count;
`ifdef ADDEND_COLLECTOR_SUM_EN
    logic [P-1:0]   partial_sum;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          check_en = 0;

    addend_collector #(
        .PRECISION_BITS(P),
        .NUM_NODES     (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .addends    (addends),
`ifdef ADDEND_COLLECTOR_SUM_EN
        .partial_sum(partial_sum),
`endif
        .out_count  (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the values of the vector being built, in arrival
    // order, and whether the vector is complete and waiting for the consumer.
    logic [P-1:0] mq[$];
    bit           mhold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mhold = 0;
        end else if (mhold) begin
            if (out_ready) begin
                mhold = 0;
                mq.delete();
            end
        end else if (in_valid) begin
            mq.push_back(in_data);
            if (in_last || mq.size() == N) mhold = 1;
        end
    end

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < mq.size(); i++) v[i*P +: P] = mq[i];
        return v;
    endfunction

    function automatic logic [P-1:0] model_sum();
        int unsigned s = 0;
        for (int i = 0; i < mq.size(); i++) s += mq[i];
        return P'(s % 256);
    endfunction

    always @(negedge clk) begin
        if (rst_n && check_en) begin
            chk("m_out_valid", {31'b0, out_valid}, {31'b0, mhold});
            chk("m_in_ready", {31'b0, in_ready}, {31'b0, !mhold});
            chk("m_addends", addends, model_vec());
            chk("m_out_count", {29'b0, out_count}, mhold ? mq.size() : 0);
`ifdef ADDEND_COLLECTOR_SUM_EN
            chk("m_partial_sum", {24'b0, partial_sum}, {24'b0, model_sum()});
`endif
        end
    end

    // Offer one value and wait (bounded) until the collector takes it.
    task automatic send(input logic [P-1:0] d, input bit last);
        int n = 0;
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_vec();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int hs[$];
        logic [31:0] tree;
        logic [P-1:0] d;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_addends", addends, 32'd0);
        chk("rst_out_count", {29'b0, out_count}, 32'd0);
        rst_n = 1'b1;
        check_en = 1;

        // Full vector
        send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
        chk("full_out_valid", {31'b0, out_valid}, 32'd1);
        chk("full_addends", addends, 32'h04030201);
        chk("full_out_count", {29'b0, out_count}, 32'd4);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
`ifdef ADDEND_COLLECTOR_SUM_EN
        chk("full_partial_sum", {24'b0, partial_sum}, 32'd10);
`endif

        // Backpressure with a pending upstream value
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_addends", addends, 32'h04030201);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("rel_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rel_addends", addends, 32'd0);
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // Short vector followed by a full one
        send(8'h10, 0); send(8'h20, 1);
        chk("short_addends", addends, 32'h00002010);
        chk("short_out_count", {29'b0, out_count}, 32'd2);
        release_vec();
        send(8'd5, 0); send(8'd6, 0); send(8'd7, 0); send(8'd8, 0);
        chk("after_short_addends", addends, 32'h08070605);
        release_vec();

        // in_last on the first element
        send(8'h5A, 1);
        chk("single_addends", addends, 32'h0000005A);
        chk("single_out_count", {29'b0, out_count}, 32'd1);
        release_vec();

        // Wrapping sum
        send(8'hFF, 0); send(8'h02, 0); send(8'h00, 0); send(8'h01, 1);
        chk("wrap_addends", addends, 32'h010002FF);
        tree = (32'(addends[7:0]) + 32'(addends[15:8]) + 32'(addends[23:16]) + 32'(addends[31:24])) % 256;
        chk("wrap_tree_sum", tree, 32'h02);
`ifdef ADDEND_COLLECTOR_SUM_EN
        chk("wrap_partial_sum", {24'b0, partial_sum}, 32'h02);
`endif
        release_vec();

        // Asynchronous reset between edges mid-fill
        send(8'd1, 0); send(8'd2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_addends", addends, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_out_count", {29'b0, out_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'd9, 0); send(8'd10, 0); send(8'd11, 0); send(8'd12, 0);
        chk("arst_after_addends", addends, 32'h0C0B0A09);
        release_vec();

        // Continuous streaming: one vector every N+1 cycles
        in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1; d = 8'h30;
        in_data = d;
        for (int c = 0; c < 30; c++) begin
            bit acc;
            if (out_valid && out_ready) hs.push_back(c);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                d = d + 8'd1;
                in_data = d;
            end
        end
        chk("stream_vectors", hs.size(), 32'd6);
        for (int i = 1; i < hs.size(); i++)
            chk("stream_period", hs[i] - hs[i-1], N + 1);
        chk("stream_values_taken", {24'b0, d}, 32'h30 + 32'd24);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        if (out_valid) release_vec();

        // Randomized traffic, checked every cycle against the model
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = P'($urandom);
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = $urandom_range(0, 1) == 1;
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
